// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces the raw push-buttons and slide
// switches. Each channel has a two-flop synchroniser, a debounce counter and a
// four-state FSM (STABLE_LO, ARM_HI, STABLE_HI, ARM_LO). The outputs are clean
// levels, a one-cycle press pulse per button and a one-cycle change pulse per switch.
// All outputs are registered.
//
// Optional feature: define INPUT_CONDITIONER_AUTOREPEAT_EN to enable button
// auto-repeat. The repeat-timing parameters REPEAT_DELAY and REPEAT_PERIOD
// exist only in that build, because the default build has no logic that uses them.
// Channels are packed as {sw_raw, btn_raw}. Buttons use the low indices.
module input_conditioner #(
  parameter int N_BTN           = 3,
  parameter int N_SW            = 2,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CNT_W           = 21
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 62500000,
  parameter int REPEAT_PERIOD   = 31250000
`endif
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_SW-1:0]  sw_change
);

  localparam int N_CH = N_BTN + N_SW;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    ARM_HI    = 2'd1,
    STABLE_HI = 2'd2,
    ARM_LO    = 2'd3
  } state_t;

  logic [N_CH-1:0]  raw_s;
  logic [N_CH-1:0]  sync1_q;
  logic [N_CH-1:0]  sync2_q;
  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]  rise_s;
  logic [N_CH-1:0]  fall_s;
  logic [N_CH-1:0]  level_q;
  logic [N_CH-1:0]  level_d;
  logic [N_BTN-1:0] btn_pulse_q;
  logic [N_BTN-1:0] btn_pulse_d;
  logic [N_SW-1:0]  sw_change_q;
  logic [N_SW-1:0]  sw_change_d;

  assign raw_s = {sw_raw, btn_raw};

  // Two-flop synchroniser per channel with no logic between the stages.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM state and counter registers. Reset discards any partial count.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= STABLE_LO;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic. Any reversal while arming restarts from the stable state.
  // Terminal count leaves ARM_*, so the counter can never wrap.
  always_comb begin
    rise_s = '0;
    fall_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE_LO: begin
          if (sync2_q[i]) begin
            state_d[i] = ARM_HI;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        ARM_HI: begin
          if (!sync2_q[i]) begin
            state_d[i] = STABLE_LO;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_TERM) begin
            state_d[i] = STABLE_HI;
            cnt_d[i]   = '0;
            rise_s[i]  = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!sync2_q[i]) begin
            state_d[i] = ARM_LO;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        ARM_LO: begin
          if (sync2_q[i]) begin
            state_d[i] = STABLE_HI;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_TERM) begin
            state_d[i] = STABLE_LO;
            cnt_d[i]   = '0;
            fall_s[i]  = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = STABLE_LO;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DLY_TERM = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_TERM = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q [N_BTN];
  logic [RPT_W-1:0] rpt_d [N_BTN];
  logic [N_BTN-1:0] rpt_en_q;
  logic [N_BTN-1:0] rpt_en_d;
  logic [N_BTN-1:0] rpt_first_q;
  logic [N_BTN-1:0] rpt_first_d;
  logic [N_BTN-1:0] rpt_fire_s;

  // Repeat timer. It is armed by an accepted press and killed by any exit from
  // STABLE_HI. It stays dead until the next accepted press, so a bounce back
  // to 1 cannot restart it.
  always_comb begin
    rpt_fire_s = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rpt_d[i]       = rpt_q[i];
      rpt_en_d[i]    = rpt_en_q[i];
      rpt_first_d[i] = rpt_first_q[i];
      if (rise_s[i]) begin
        rpt_d[i]       = '0;
        rpt_en_d[i]    = 1'b1;
        rpt_first_d[i] = 1'b1;
      end else if ((state_q[i] == STABLE_HI) && sync2_q[i] && rpt_en_q[i]) begin
        if (rpt_q[i] == (rpt_first_q[i] ? RPT_DLY_TERM : RPT_PER_TERM)) begin
          rpt_fire_s[i]  = 1'b1;
          rpt_d[i]       = '0;
          rpt_first_d[i] = 1'b0;
        end else begin
          rpt_d[i]       = rpt_q[i] + RPT_W'(1);
        end
      end else begin
        rpt_d[i]       = '0;
        rpt_en_d[i]    = 1'b0;
        rpt_first_d[i] = 1'b0;
      end
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        rpt_q[i] <= '0;
      end
      rpt_en_q    <= '0;
      rpt_first_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        rpt_q[i] <= rpt_d[i];
      end
      rpt_en_q    <= rpt_en_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  // Output decode from accepted FSM transitions.
  always_comb begin
    level_d     = (level_q | rise_s) & ~fall_s;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    btn_pulse_d = rise_s[N_BTN-1:0] | rpt_fire_s;
`else
    btn_pulse_d = rise_s[N_BTN-1:0];
`endif
    sw_change_d = rise_s[N_CH-1:N_BTN] | fall_s[N_CH-1:N_BTN];
  end

  // Output registers, so no raw input reaches an output combinationally.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      level_q     <= '0;
      btn_pulse_q <= '0;
      sw_change_q <= '0;
    end else begin
      level_q     <= level_d;
      btn_pulse_q <= btn_pulse_d;
      sw_change_q <= sw_change_d;
    end
  end

  assign btn_level = level_q[N_BTN-1:0];
  assign sw_level  = level_q[N_CH-1:N_BTN];
  assign btn_pulse = btn_pulse_q;
  assign sw_change = sw_change_q;

endmodule
